vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_pix_tick.sv | 32 +++
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Timing constants and shared types for the 640x480@60 raster generator.
// The default values describe the standard VGA mode; the top module may override them.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    // One entry of the sync/blank delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    function automatic logic in_window(input logic [CNT_W-1:0] val, input int first, input int last);
        return (int'(val) >= first) && (int'(val) <= last);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: tick is combinational on the last divider count,
// pix_en is its registered copy so the renderers see it aligned with x/y.
module vga_pix_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en <= tick;
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel counters, visible-area/sync decode and a sync delay line.
// Optional macro VGA_FRAME_CNT_EN adds an 8-bit frame_count output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active_pixels,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_count
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    // Counters are 10 bits wide; reject parameter sets that would overflow them.
    if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be below 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be 1..4");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..7");
    end

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             visible;
    logic             hs_raw;
    logic             vs_raw;
    sync_t            sync_raw;
    sync_t            sync_out;

    vga_pix_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .pix_en (pix_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                if (v_cnt == CNT_W'(V_TOTAL - 1)) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign visible = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));

    // Decode uses the pre-increment counters, so outputs trail the counters by one pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            x             <= '0;
            y             <= '0;
            active_pixels <= 1'b0;
            frame_start   <= 1'b0;
            hs_raw        <= SYNC_IDLE.hs;
            vs_raw        <= SYNC_IDLE.vs;
        end else begin
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                active_pixels <= visible;
                x             <= visible ? h_cnt : '0;
                y             <= visible ? v_cnt : '0;
                hs_raw        <= !in_window(h_cnt, HS_START, HS_END);
                vs_raw        <= !in_window(v_cnt, VS_START, VS_END);
            end
        end
    end

    assign sync_raw = '{hs: hs_raw, vs: vs_raw, blank_n: active_pixels};

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign sync_out = sync_raw;
    end else begin : g_delay
        sync_t stage [SYNC_DELAY];

        // Shifts every clk so the delay is counted in clks, not pixels.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < SYNC_DELAY; i++) begin
                    stage[i] <= SYNC_IDLE;
                end
            end else begin
                stage[0] <= sync_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign sync_out = stage[SYNC_DELAY-1];
    end

    assign vga_hs      = sync_out.hs;
    assign vga_vs      = sync_out.vs;
    assign vga_blank_n = sync_out.blank_n;

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (frame_start) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: five vga_timing_gen instances (standard mode at several delays,
// plus two reduced-size rasters) compared every clk against a closed-form timing model.
module tb_vga_timing_gen;

    localparam int NI = 5;
    // 0: standard, 1: delay 0, 2: delay 3, 3: small raster div 1, 4: small raster div 3 delay 7
    localparam int P_HA [NI] = '{640, 640, 640, 6, 6};
    localparam int P_HF [NI] = '{16, 16, 16, 1, 1};
    localparam int P_HS [NI] = '{96, 96, 96, 2, 2};
    localparam int P_HB [NI] = '{48, 48, 48, 1, 1};
    localparam int P_VA [NI] = '{480, 480, 480, 4, 4};
    localparam int P_VF [NI] = '{10, 10, 10, 1, 1};
    localparam int P_VS [NI] = '{2, 2, 2, 1, 1};
    localparam int P_VB [NI] = '{33, 33, 33, 1, 1};
    localparam int P_CD [NI] = '{2, 2, 2, 1, 3};
    localparam int P_SD [NI] = '{2, 0, 3, 1, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic       pe_w  [NI];
    logic [9:0] x_w   [NI];
    logic [9:0] y_w   [NI];
    logic       act_w [NI];
    logic       fs_w  [NI];
    logic       hs_w  [NI];
    logic       vs_w  [NI];
    logic       bn_w  [NI];
    logic [7:0] fc_w  [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE   (P_HA[gi]),
            .H_FP       (P_HF[gi]),
            .H_SYNC     (P_HS[gi]),
            .H_BP       (P_HB[gi]),
            .V_ACTIVE   (P_VA[gi]),
            .V_FP       (P_VF[gi]),
            .V_SYNC     (P_VS[gi]),
            .V_BP       (P_VB[gi]),
            .CLK_DIV    (P_CD[gi]),
            .SYNC_DELAY (P_SD[gi])
        ) u_dut (
`ifdef VGA_FRAME_CNT_EN
            .frame_count   (fc_w[gi]),
`endif
            .clk           (clk),
            .rst           (rst),
            .pix_en        (pe_w[gi]),
            .x             (x_w[gi]),
            .y             (y_w[gi]),
            .active_pixels (act_w[gi]),
            .frame_start   (fs_w[gi]),
            .vga_hs        (hs_w[gi]),
            .vga_vs        (vs_w[gi]),
            .vga_blank_n   (bn_w[gi])
        );
`ifndef VGA_FRAME_CNT_EN
        assign fc_w[gi] = 8'h00;
`endif
    end

    typedef struct {
        int          p;
        int          n;
        logic [33:0] v;
    } sb_t;

    sb_t sb_q [$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n        = 0;
    int  fc_m [NI];

    bit  seg2 = 1'b0;
    int  cnt_pe = 0, cnt_act = 0, hs_low = 0, ymax = 0;
    int  hs_first [NI];
    int  bn_first [NI];
    int  fs_cnt   [NI];
    int  fs_at    [NI][2];

    // Expected outputs after the n-th active clk edge since reset release (n = 0: in reset).
    // Vector layout: {frame_count, pix_en, x, y, active, frame_start, hs, vs, blank_n}.
    function automatic logic [33:0] expect_vec(input int p, input int nn, input int fc);
        int ht = P_HA[p] + P_HF[p] + P_HS[p] + P_HB[p];
        int vt = P_VA[p] + P_VF[p] + P_VS[p] + P_VB[p];
        int cd = P_CD[p];
        int q, h, v, m;
        logic       pe, act, fs, hs, vs, bn;
        logic [9:0] ex, ey;
        logic [7:0] efc = 8'h00;
        pe = (nn >= cd) && (nn % cd == 0);
        act = 1'b0; fs = 1'b0; ex = '0; ey = '0;
        if (nn >= cd) begin
            q = nn / cd - 1;
            h = q % ht;
            v = (q / ht) % vt;
            act = (h < P_HA[p]) && (v < P_VA[p]);
            if (act) begin
                ex = 10'(h);
                ey = 10'(v);
            end
            fs = pe && (h == 0) && (v == 0);
        end
        m = nn - P_SD[p];
        hs = 1'b1; vs = 1'b1; bn = 1'b0;
        if (m >= cd) begin
            q = m / cd - 1;
            h = q % ht;
            v = (q / ht) % vt;
            hs = !((h >= P_HA[p] + P_HF[p]) && (h < P_HA[p] + P_HF[p] + P_HS[p]));
            vs = !((v >= P_VA[p] + P_VF[p]) && (v < P_VA[p] + P_VF[p] + P_VS[p]));
            bn = (h < P_HA[p]) && (v < P_VA[p]);
        end
`ifdef VGA_FRAME_CNT_EN
        efc = 8'(fc);
`endif
        return {efc, pe, ex, ey, act, fs, hs, vs, bn};
    endfunction

    function automatic logic [33:0] obs_vec(input int p);
        return {fc_w[p], pe_w[p], x_w[p], y_w[p], act_w[p], fs_w[p], hs_w[p], vs_w[p], bn_w[p]};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r);
        sb_t         s;
        logic [33:0] o;
        rst = r;
        @(posedge clk);
        n = r ? 0 : n + 1;
        for (int p = 0; p < NI; p++) begin
            s.p = p;
            s.n = n;
            s.v = expect_vec(p, n, fc_m[p]);
            sb_q.push_back(s);
            if (r) fc_m[p] = 0;
            else if (s.v[3]) fc_m[p] = (fc_m[p] + 1) % 256;
        end
        @(negedge clk);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            o = obs_vec(s.p);
            n_checks++;
            assert (o === s.v) else begin
                n_errors++;
                $error("FAIL sb inst%0d n=%0d observed=%h expected=%h", s.p, s.n, o, s.v);
            end
        end
        if (seg2) begin
            if (n <= 1600 && pe_w[0]) begin
                cnt_pe++;
                if (act_w[0]) cnt_act++;
            end
            if (n <= 1700 && !hs_w[0]) hs_low++;
            if (int'(y_w[3]) > ymax) ymax = int'(y_w[3]);
            for (int p = 0; p < NI; p++) begin
                if (!hs_w[p] && hs_first[p] < 0) hs_first[p] = n;
                if (bn_w[p] && bn_first[p] < 0) bn_first[p] = n;
                if (fs_w[p]) begin
`ifdef VGA_FRAME_CNT_EN
                    if (p == 3) check("frame_count_seq", int'(fc_w[3]), fs_cnt[3] % 256);
`endif
                    if (fs_cnt[p] < 2) fs_at[p][fs_cnt[p]] = n;
                    fs_cnt[p]++;
                end
            end
        end
    endtask

    initial begin
        for (int p = 0; p < NI; p++) begin
            fc_m[p]     = 0;
            hs_first[p] = -1;
            bn_first[p] = -1;
            fs_cnt[p]   = 0;
            fs_at[p][0] = -1;
            fs_at[p][1] = -1;
        end

        repeat (3) step(1'b1);
        repeat (602) step(1'b0);
        // Mid-line reset for one clk; everything restarts from the reset state.
        step(1'b1);
        seg2 = 1'b1;
        repeat (19000) step(1'b0);

        check("line_pix_en", cnt_pe, 800);
        check("line_active", cnt_act, 640);
        check("hs_low_clks", hs_low, 192);
        check("hs_first_fall", hs_first[0], 1316);
        check("hs_shift_d3_d0", hs_first[2] - hs_first[1], 3);
        check("bn_shift_d3_d0", bn_first[2] - bn_first[1], 3);
        check("bn_first_rise", bn_first[0], 4);
        check("first_fs_std", fs_at[0][0], 2);
        check("frame_spacing_s1", fs_at[3][1] - fs_at[3][0], 70);
        check("frame_spacing_s3", fs_at[4][1] - fs_at[4][0], 210);
        check("first_fs_s3", fs_at[4][0], 3);
        check("ymax_s1", ymax, 3);
        check("frames_s1", fs_cnt[3], 272);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
